// File: rtl/unidade_controle_exp6.sv
// Control unit for the memory game: shows the stored sequence each round, then collects and
// checks the player's moves, with a per-move timeout and difficulty latched at game start.
module unidade_controle_exp6 #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SHOW_ON        = 500,
  parameter int unsigned SHOW_OFF       = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_endereco,
  input  logic       fim_rodada,
  output logic       zera_endereco,
  output logic       conta_endereco,
  output logic       zera_rodada,
  output logic       conta_rodada,
  output logic       registra,
  output logic       leds_mostra,
  output logic       dificuldade_reg,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned MaxShow   = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > MaxShow) ? TIMEOUT_CYCLES : MaxShow;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] ShowOnLast  = TimerW'(SHOW_ON - 1);
  localparam logic [TimerW-1:0] ShowOffLast = TimerW'(SHOW_OFF - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPreparacao   = 4'h1,
    StMostraLed    = 4'h2,
    StMostraApaga  = 4'h3,
    StProxMostra   = 4'h4,
    StIniciaJogada = 4'h5,
    StEspera       = 4'h6,
    StRegistra     = 4'h7,
    StCompara      = 4'h8,
    StProxJogada   = 4'h9,
    StProxRodada   = 4'hB,
    StFimAcerto    = 4'hC,
    StFimTimeout   = 4'hD,
    StFimErro      = 4'hE
  } estado_e;

  estado_e           state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              dificuldade_q, dificuldade_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StInicial;
      timer_q       <= '0;
      dificuldade_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      dificuldade_q <= dificuldade_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInicial:      if (jogar) state_d = StPreparacao;
      StPreparacao:   state_d = StMostraLed;
      StMostraLed:    if (timer_q == ShowOnLast) state_d = StMostraApaga;
      StMostraApaga: begin
        if (timer_q == ShowOffLast) begin
          state_d = fim_endereco ? StIniciaJogada : StProxMostra;
        end
      end
      StProxMostra:   state_d = StMostraLed;
      StIniciaJogada: state_d = StEspera;
      StEspera: begin
        // A press in the last allowed cycle still counts as a move.
        if (jogada) begin
          state_d = StRegistra;
        end else if (timer_q == TimeoutLast) begin
          state_d = StFimTimeout;
        end
      end
      StRegistra:     state_d = StCompara;
      StCompara: begin
        if (!igual) begin
          state_d = StFimErro;
        end else if (fim_endereco && fim_rodada) begin
          state_d = StFimAcerto;
        end else if (fim_endereco) begin
          state_d = StProxRodada;
        end else begin
          state_d = StProxJogada;
        end
      end
      StProxJogada:   state_d = StEspera;
      StProxRodada:   state_d = StMostraLed;
      StFimAcerto, StFimTimeout, StFimErro: begin
        if (jogar) state_d = StPreparacao;
      end
      default:        state_d = StInicial;
    endcase
  end

  // One counter serves both the show phases and the move timeout: it restarts on every state
  // change, which also covers the clears in INICIA_JOGADA and PROX_JOGADA.
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) &&
        ((state_q == StMostraLed) || (state_q == StMostraApaga) || (state_q == StEspera))) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_comb begin
    dificuldade_d = dificuldade_q;
    if (state_q == StPreparacao) dificuldade_d = dificuldade;
  end

  always_comb begin
    zera_endereco  = 1'b0;
    conta_endereco = 1'b0;
    zera_rodada    = 1'b0;
    conta_rodada   = 1'b0;
    registra       = 1'b0;
    leds_mostra    = 1'b0;
    pronto         = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    db_timeout     = 1'b0;
    unique case (state_q)
      StPreparacao: begin
        zera_endereco = 1'b1;
        zera_rodada   = 1'b1;
      end
      StMostraLed:    leds_mostra    = 1'b1;
      StProxMostra:   conta_endereco = 1'b1;
      StIniciaJogada: zera_endereco  = 1'b1;
      StRegistra:     registra       = 1'b1;
      StProxJogada:   conta_endereco = 1'b1;
      StProxRodada: begin
        conta_rodada  = 1'b1;
        zera_endereco = 1'b1;
      end
      StFimAcerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StFimTimeout: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      StFimErro: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      default: ;
    endcase
  end

  assign dificuldade_reg = dificuldade_q;
  assign db_estado       = state_q;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Bench for unidade_controle_exp6: a small datapath model (ROM, address/round counters) plays
// randomized games and checks the controller against the game rules.
module tb_unidade_controle_exp6;

  localparam int unsigned TO  = 20;
  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 2;
  localparam int MWin = 0, MWrong = 1, MTimeout = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic       dificuldade = 1'b0;
  logic       jogada = 1'b0;
  logic       igual, fim_endereco, fim_rodada;
  logic       zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra;
  logic       leds_mostra, dificuldade_reg, pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_rodada = 0;
  int game_limit = 7;

  logic [1:0] rom [16];
  logic [1:0] btn = 2'b00;
  logic [3:0] addr_m, round_m;
  logic [1:0] move_m;
  logic [9:0] outs;

  unidade_controle_exp6 #(
    .TIMEOUT_CYCLES(TO),
    .SHOW_ON       (ON),
    .SHOW_OFF      (OFF)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .jogar          (jogar),
    .dificuldade    (dificuldade),
    .jogada         (jogada),
    .igual          (igual),
    .fim_endereco   (fim_endereco),
    .fim_rodada     (fim_rodada),
    .zera_endereco  (zera_endereco),
    .conta_endereco (conta_endereco),
    .zera_rodada    (zera_rodada),
    .conta_rodada   (conta_rodada),
    .registra       (registra),
    .leds_mostra    (leds_mostra),
    .dificuldade_reg(dificuldade_reg),
    .pronto         (pronto),
    .acertou        (acertou),
    .errou          (errou),
    .db_timeout     (db_timeout),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // Datapath model driven by the controller's commands.
  always @(posedge clock) begin
    if (!reset) begin
      addr_m  <= '0;
      round_m <= '0;
      move_m  <= '0;
    end else begin
      if (zera_endereco) addr_m <= '0;
      else if (conta_endereco) addr_m <= addr_m + 4'd1;
      if (zera_rodada) round_m <= '0;
      else if (conta_rodada) round_m <= round_m + 4'd1;
      if (registra) move_m <= btn;
    end
  end

  assign igual        = (move_m == rom[addr_m]);
  assign fim_endereco = (addr_m == round_m);
  assign fim_rodada   = (32'(round_m) == game_limit);
  assign outs = {zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra,
                 leds_mostra, pronto, acertou, errou, db_timeout};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (conta_rodada === 1'b1) n_rodada++;
    @(posedge clock);
    #1;
  endtask

  // Expected flags order: pronto, acertou, errou, db_timeout.
  task automatic check_final(input string tag, input int code, input logic [3:0] flags);
    chk({tag, "_state"}, 32'(db_estado), code);
    chk({tag, "_flags"}, 32'({pronto, acertou, errou, db_timeout, leds_mostra}),
        32'({flags, 1'b0}));
    repeat (3) tick();
    chk({tag, "_hold"}, 32'({db_estado, pronto}), 32'({code[3:0], 1'b1}));
  endtask

  // Entered on the first lit cycle of round r; returns in ESPERA after the last item.
  task automatic show_round(input int r);
    int on;
    int off;
    for (int k = 0; k <= r; k++) begin
      chk("show_addr", 32'(addr_m), k);
      on = 0;
      while (leds_mostra === 1'b1 && on < 64) begin
        jogada = 1'($urandom);
        tick();
        on++;
      end
      jogada = 1'b0;
      chk("show_on", on, ON);
      off = 0;
      while (leds_mostra !== 1'b1 && db_estado !== 4'h6 && off < 64) begin
        tick();
        off++;
      end
      chk("show_off", off, OFF + 1);
      chk("show_next", 32'(db_estado), (k == r) ? 6 : 2);
    end
  endtask

  task automatic play_game(input bit dif, input int mode, input int bad_r, input int bad_j);
    int  limit;
    int  delay;
    bit  done;
    bit  wrong;
    limit = dif ? 15 : 7;
    for (int i = 0; i < 16; i++) rom[i] = 2'($urandom);
    game_limit  = limit;
    dificuldade = dif;
    n_rodada    = 0;
    jogar       = 1'b1;
    tick();
    jogar = 1'b0;
    chk("preparacao", 32'({db_estado, zera_endereco, zera_rodada}), 32'({4'h1, 2'b11}));
    tick();
    chk("dif_latched", 32'(dificuldade_reg), 32'(dif));
    dificuldade = ~dif;
    done = 1'b0;
    for (int r = 0; r <= limit && !done; r++) begin
      show_round(r);
      for (int j = 0; j <= r && !done; j++) begin
        delay = (j == r) ? int'(TO) - 1 : int'($urandom_range(0, TO - 2));
        if (mode == MTimeout && r == bad_r && j == bad_j) delay = TO;
        for (int c = 0; c < delay; c++) begin
          if (c == int'(TO) - 1) chk("no_early_timeout", 32'(db_estado), 6);
          jogar = 1'($urandom);
          tick();
        end
        jogar = 1'b0;
        if (delay >= int'(TO)) begin
          check_final("timeout", 13, 4'b1011);
          done = 1'b1;
        end else begin
          chk("espera", 32'(db_estado), 6);
          wrong = (mode == MWrong && r == bad_r && j == bad_j);
          btn = wrong ? (rom[j] ^ 2'b01) : rom[j];
          jogada = 1'b1;
          tick();
          jogada = 1'b0;
          chk("registra", 32'({db_estado, registra}), 32'({4'h7, 1'b1}));
          tick();
          tick();
          if (wrong) begin
            check_final("erro", 14, 4'b1010);
            done = 1'b1;
          end else if (j == r && r == limit) begin
            check_final("acerto", 12, 4'b1100);
            chk("rodadas", n_rodada, limit);
            chk("dif_kept", 32'(dificuldade_reg), 32'(dif));
            done = 1'b1;
          end else if (j == r) begin
            chk("prox_rodada", 32'({db_estado, conta_rodada, zera_endereco}),
                32'({4'hB, 2'b11}));
            tick();
          end else begin
            chk("prox_jogada", 32'({db_estado, conta_endereco}), 32'({4'h9, 1'b1}));
            tick();
            chk("back_espera", 32'(db_estado), 6);
          end
        end
      end
    end
    chk("game_ended", 32'(done), 1);
  endtask

  initial begin
    int br;
    for (int i = 0; i < 16; i++) rom[i] = 2'b00;
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(db_estado), 0);
    chk("reset_outs", 32'(outs), 0);
    chk("reset_dif", 32'(dificuldade_reg), 0);
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_state", 32'(db_estado), 0);
    chk("idle_outs", 32'(outs), 0);

    play_game(1'b0, MWin, 0, 0);
    play_game(1'b0, MWrong, 2, 1);
    play_game(1'b1, MWin, 0, 0);
    br = int'($urandom_range(0, 3));
    play_game(1'($urandom), MTimeout, br, int'($urandom_range(0, br)));
    br = int'($urandom_range(0, 5));
    play_game(1'($urandom), MWrong, br, int'($urandom_range(0, br)));

    // Asynchronous reset in the middle of the show phase.
    dificuldade = 1'b1;
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    repeat (3) tick();
    chk("pre_reset_show", 32'({db_estado, dificuldade_reg}), 32'({4'h2, 1'b1}));
    #2 reset = 1'b0;
    #1;
    chk("async_reset_state", 32'(db_estado), 0);
    chk("async_reset_outs", 32'(outs), 0);
    chk("async_reset_dif", 32'(dificuldade_reg), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("after_reset_idle", 32'(db_estado), 0);
    play_game(1'b0, MWrong, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
